// File: rtl/pong_score_keeper.sv
// Pong score keeper: edge-detects goal/new-game inputs, sequences serve/play/over,
// and holds both players' scores as registered two-digit BCD for the score renderers.
module pong_score_keeper #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       GoalL,
  input  logic       GoalR,
  input  logic       NewGame,
  output logic [3:0] ScoreLTens,
  output logic [3:0] ScoreLOnes,
  output logic [3:0] ScoreRTens,
  output logic [3:0] ScoreROnes,
  output logic       Playing,
  output logic       GameOver,
  output logic       Winner,
  output logic       ScoreEvent
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam int             CNT_W    = 26;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [7:0]     WIN_BCD  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             goal_l_q, goal_r_q, new_game_q;
  logic             armed;
  logic             goal_l_rise, goal_r_rise, new_game_rise;
  logic [7:0]       l_inc, r_inc;
  logic [3:0]       l_tens_next, l_ones_next, r_tens_next, r_ones_next;
  logic             winner_next, event_next;

  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    else              return {tens, ones + 4'd1};
  endfunction

  // The first clock after reset only primes the input copies, so a level held
  // high through reset release has to drop low before it can count as an edge.
  assign goal_l_rise   = armed & GoalL   & ~goal_l_q;
  assign goal_r_rise   = armed & GoalR   & ~goal_r_q;
  assign new_game_rise = armed & NewGame & ~new_game_q;

  assign l_inc = bcd_inc(ScoreLTens, ScoreLOnes);
  assign r_inc = bcd_inc(ScoreRTens, ScoreROnes);

  always_comb begin
    state_next  = state;
    count_next  = count;
    l_tens_next = ScoreLTens;
    l_ones_next = ScoreLOnes;
    r_tens_next = ScoreRTens;
    r_ones_next = ScoreROnes;
    winner_next = Winner;
    event_next  = 1'b0;
    if (new_game_rise) begin
      l_tens_next = 4'd0;
      l_ones_next = 4'd0;
      r_tens_next = 4'd0;
      r_ones_next = 4'd0;
      winner_next = 1'b0;
      count_next  = CNT_LOAD;
      state_next  = SERVE;
    end else begin
      case (state)
        SERVE: begin
          if (count == '0) state_next = PLAY;
          else             count_next = count - 1'b1;
        end
        PLAY: begin
          // Simultaneous goals cancel out; only a lone goal edge scores.
          if (goal_l_rise ^ goal_r_rise) begin
            event_next = 1'b1;
            if (goal_l_rise) begin
              {l_tens_next, l_ones_next} = l_inc;
              if (l_inc == WIN_BCD) begin
                state_next  = OVER;
                winner_next = 1'b0;
              end else begin
                state_next = SERVE;
                count_next = CNT_LOAD;
              end
            end else begin
              {r_tens_next, r_ones_next} = r_inc;
              if (r_inc == WIN_BCD) begin
                state_next  = OVER;
                winner_next = 1'b1;
              end else begin
                state_next = SERVE;
                count_next = CNT_LOAD;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      goal_l_q   <= 1'b0;
      goal_r_q   <= 1'b0;
      new_game_q <= 1'b0;
      armed      <= 1'b0;
      ScoreLTens <= 4'd0;
      ScoreLOnes <= 4'd0;
      ScoreRTens <= 4'd0;
      ScoreROnes <= 4'd0;
      Playing    <= 1'b0;
      GameOver   <= 1'b0;
      Winner     <= 1'b0;
      ScoreEvent <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      goal_l_q   <= GoalL;
      goal_r_q   <= GoalR;
      new_game_q <= NewGame;
      armed      <= 1'b1;
      ScoreLTens <= l_tens_next;
      ScoreLOnes <= l_ones_next;
      ScoreRTens <= r_tens_next;
      ScoreROnes <= r_ones_next;
      Playing    <= (state_next == PLAY);
      GameOver   <= (state_next == OVER);
      Winner     <= winner_next;
      ScoreEvent <= event_next;
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Self-checking bench for pong_score_keeper: a behavioural model pushes expected
// outputs into a scoreboard as each cycle is driven; they are popped after the edge.
module tb_pong_score_keeper;

  localparam int D = 4;
  localparam int W = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       GoalL = 1'b0, GoalR = 1'b0, NewGame = 1'b0;
  logic [3:0] ScoreLTens, ScoreLOnes, ScoreRTens, ScoreROnes;
  logic       Playing, GameOver, Winner, ScoreEvent;

  pong_score_keeper #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
    .clk(clk), .reset(reset), .GoalL(GoalL), .GoalR(GoalR), .NewGame(NewGame),
    .ScoreLTens(ScoreLTens), .ScoreLOnes(ScoreLOnes),
    .ScoreRTens(ScoreRTens), .ScoreROnes(ScoreROnes),
    .Playing(Playing), .GameOver(GameOver), .Winner(Winner), .ScoreEvent(ScoreEvent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [19:0] sb[$];

  // Model: integer scores and a remaining-cycles countdown
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;
  int m_st, m_sl, m_sr, m_rem;
  bit m_win, m_ev, m_pl, m_pr, m_pn, m_armed;

  function automatic logic [19:0] expVec();
    return {4'(m_sl / 10), 4'(m_sl % 10), 4'(m_sr / 10), 4'(m_sr % 10),
            (m_st == M_PLAY), (m_st == M_OVER), m_win, m_ev};
  endfunction

  function automatic logic [19:0] dutVec();
    return {ScoreLTens, ScoreLOnes, ScoreRTens, ScoreROnes,
            Playing, GameOver, Winner, ScoreEvent};
  endfunction

  function automatic void modelReset();
    m_st = M_IDLE; m_sl = 0; m_sr = 0; m_rem = 0;
    m_win = 0; m_ev = 0; m_pl = 0; m_pr = 0; m_pn = 0; m_armed = 0;
  endfunction

  function automatic void modelStep();
    bit rl, rr, rn;
    rl = m_armed && GoalL && !m_pl;
    rr = m_armed && GoalR && !m_pr;
    rn = m_armed && NewGame && !m_pn;
    m_ev = 0;
    if (rn) begin
      m_sl = 0; m_sr = 0; m_win = 0; m_st = M_SERVE; m_rem = D;
    end else if (m_st == M_SERVE) begin
      m_rem--;
      if (m_rem == 0) m_st = M_PLAY;
    end else if (m_st == M_PLAY && (rl != rr)) begin
      m_ev = 1;
      if (rl) m_sl++; else m_sr++;
      if ((rl && m_sl == W) || (rr && m_sr == W)) begin
        m_st = M_OVER; m_win = rr;
      end else begin
        m_st = M_SERVE; m_rem = D;
      end
    end
    m_pl = GoalL; m_pr = GoalR; m_pn = NewGame; m_armed = 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] actual, input logic [19:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic gl, input logic gr, input logic ng, input string tag);
    @(negedge clk);
    GoalL = gl; GoalR = gr; NewGame = ng;
    modelStep();
    sb.push_back(expVec());
    @(posedge clk);
    #1;
    checkOutput(tag, dutVec(), sb.pop_front());
  endtask

  task automatic scorePoint(input logic left, input string tag);
    applyStimulus(left, !left, 1'b0, tag);
    repeat (D) applyStimulus(1'b0, 1'b0, 1'b0, "serve_after_point");
  endtask

  // Called just after a check (posedge+1); asserts reset mid-cycle
  task automatic assertReset(input string tag);
    #2;
    reset = 1'b0;
    modelReset();
    sb.push_back(expVec());
    #1;
    checkOutput(tag, dutVec(), sb.pop_front());
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", dutVec(), 20'h0);
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    modelReset();
    #1 reset = 1'b0;
    #1 checkOutput("reset", dutVec(), 20'h0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_hold", dutVec(), 20'h0);
    releaseReset();

    applyStimulus(1, 0, 0, "idle_goal");
    applyStimulus(0, 0, 0, "idle");
    applyStimulus(1, 0, 0, "idle_goal2");
    applyStimulus(0, 0, 0, "idle");

    applyStimulus(0, 0, 1, "newgame");
    repeat (D - 1) applyStimulus(0, 0, 0, "serve");
    checkOutput("playing_before_serve_end", {19'h0, Playing}, 20'h0);
    applyStimulus(0, 0, 0, "serve_end");
    checkOutput("playing_after_serve", {19'h0, Playing}, 20'h1);

    repeat (10) applyStimulus(1, 0, 0, "held_goal");
    applyStimulus(0, 0, 0, "held_release");
    checkOutput("held_left_score", {12'h0, ScoreLTens, ScoreLOnes}, 20'h01);

    repeat (8) scorePoint(1, "left_point");
    checkOutput("left_nine", {12'h0, ScoreLTens, ScoreLOnes}, 20'h09);
    scorePoint(1, "left_carry");
    checkOutput("left_carry", {12'h0, ScoreLTens, ScoreLOnes}, 20'h10);

    applyStimulus(1, 1, 0, "simultaneous");
    checkOutput("simul_playing", {19'h0, Playing}, 20'h1);
    checkOutput("simul_scores", {4'h0, ScoreLTens, ScoreLOnes, ScoreRTens, ScoreROnes}, 20'h01000);
    applyStimulus(0, 0, 0, "simul_release");

    repeat (10) scorePoint(0, "right_point");
    applyStimulus(0, 1, 0, "win");
    checkOutput("win_right", {12'h0, ScoreRTens, ScoreROnes}, 20'h11);
    checkOutput("win_flags", {17'h0, Playing, GameOver, Winner}, 20'h3);

    applyStimulus(0, 0, 0, "over");
    applyStimulus(1, 0, 0, "over_goal_l");
    applyStimulus(0, 0, 0, "over");
    applyStimulus(0, 1, 0, "over_goal_r");
    checkOutput("over_frozen", {4'h0, ScoreLTens, ScoreLOnes, ScoreRTens, ScoreROnes}, 20'h01011);

    applyStimulus(0, 0, 1, "restart");
    checkOutput("restart_clear", {3'h0, ScoreLTens, ScoreLOnes, ScoreRTens, ScoreROnes, GameOver}, 20'h0);
    repeat (D) applyStimulus(0, 0, 0, "restart_serve");

    repeat (4) scorePoint(1, "left_point2");
    applyStimulus(1, 0, 0, "left_five");
    applyStimulus(0, 0, 0, "serve_mid");
    checkOutput("left_five_serve", {15'h0, ScoreLOnes, Playing}, 20'h0A);
    assertReset("reset_mid_serve");
    releaseReset();
    applyStimulus(0, 0, 0, "post_reset");
    applyStimulus(1, 0, 0, "post_reset_goal");
    repeat (D + 1) applyStimulus(0, 0, 0, "post_reset_idle");

    NewGame = 1'b1;
    assertReset("reset_newgame_held");
    releaseReset();
    repeat (3) applyStimulus(0, 0, 1, "newgame_held_release");
    repeat (D + 1) applyStimulus(0, 0, 1, "newgame_still_held");
    checkOutput("held_newgame_idle", {19'h0, Playing}, 20'h0);
    applyStimulus(0, 0, 0, "newgame_low");
    applyStimulus(0, 0, 1, "newgame_after_low");
    repeat (D) applyStimulus(0, 0, 0, "serve3");
    checkOutput("playing_after_held_ng", {19'h0, Playing}, 20'h1);

    checkOutput("scoreboard_empty", 20'(sb.size()), 20'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
# pong_score_keeper

Tracks both players' Pong scores, sequences serve / play / game-over, and drives the per-digit BCD values consumed by the `digital_ssd` score renderers. It sits between the ball/collision logic, which raises goal flags, and the four `digital_ssd` instances, which receive `ScoreLTens`, `ScoreLOnes`, `ScoreRTens` and `ScoreROnes` on their `Value` inputs. It also gates ball motion through `Playing`.

## Interface
- `WIN_SCORE`, default 11: score that ends the game; legal range 1..99.
- `SERVE_DELAY`, default 25_000_000: cycles the ball is held before each serve; legal range 1..2^25.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `GoalL`  in  1  level flag from ball logic: left player scored; may stay high for many cycles.
- `GoalR`  in  1  level flag from ball logic: right player scored.
- `NewGame`  in  1  level/button: start or restart a game; synchronous to `clk`.
- `ScoreLTens`, `ScoreLOnes`  out  4 each  left score as BCD, 0..9 per digit.
- `ScoreRTens`, `ScoreROnes`  out  4 each  right score as BCD.
- `Playing`  out  1  high only in PLAY; ball logic moves the ball only when this is high.
- `GameOver`  out  1  high in OVER.
- `Winner`  out  1  0 = left won, 1 = right won; valid while `GameOver` is high.
- `ScoreEvent`  out  1  one-cycle pulse on each credited point.

## Operation
- **Edge detection.** `GoalL`, `GoalR` and `NewGame` are each edge-detected against a registered copy. The registered copies reset to 0. Only 0→1 transitions act, so a held level counts once.
- **States:**
  - IDLE (reset state).
  - SERVE (delay counter running).
  - PLAY.
  - OVER.
- **Transitions:**
  - NewGame edge, from any state: clear all score digits, load the delay counter, go to SERVE. This has priority over any goal edge in the same cycle.
  - SERVE: decrement the counter each cycle; after exactly `SERVE_DELAY` cycles, go to PLAY.
  - PLAY, exactly one goal edge: increment that player's score and pulse `ScoreEvent`.
    - If the new score equals `WIN_SCORE`: go to OVER and set `Winner`.
    - Otherwise: reload the counter and go to SERVE.
  - PLAY, GoalL and GoalR edges in the same cycle: ignore both; stay in PLAY; no score change.
  - Goal edges in IDLE, SERVE or OVER: ignored.
  - OVER: scores and `Winner` are frozen until a NewGame edge.
- **BCD arithmetic.**
  - Ones 0..8: ones + 1.
  - Ones 9: ones becomes 0, tens + 1.
  - Tens never exceeds 9, because `WIN_SCORE` ≤ 99.
  - The win compare uses local constants `WIN_SCORE/10` and `WIN_SCORE%10` against the post-increment digits.
- **Reset values:**
  - All score digits 0; `Playing`, `GameOver`, `Winner` and `ScoreEvent` all 0.
  - State IDLE; counter 0.

## Timing
- Edge k is the first edge at which `GoalL` is sampled high after being sampled low. The new score digits, `ScoreEvent` = 1 and `Playing` = 0 are all visible after edge k. `ScoreEvent` returns to 0 after edge k+1.
- After a non-winning point, `Playing` is low for exactly `SERVE_DELAY` cycles and reasserts after edge k+`SERVE_DELAY`.
- A NewGame edge sampled at edge k clears the scores after edge k; `Playing` rises after edge k+`SERVE_DELAY`.
- On a winning point, `GameOver` and `Winner` are valid after edge k, the same cycle as the final score.
- Asserting `reset` at any time, including mid-SERVE or in the same cycle as a goal, forces all reset values immediately, without waiting for `clk`.
- `GoalL` or `NewGame` held high through reset release produces no edge: the input must first be sampled low.
- Score outputs are registered and glitch-free; `digital_ssd` adds its own one-cycle register.

## Test plan
Benches override `SERVE_DELAY` = 4 and `WIN_SCORE` = 11.
- **Reset then idle:** hold `reset` low, then release; pulse `GoalL` → all outputs 0, scores remain 00/00, `Playing` = 0.
- **Start and serve:** one-cycle `NewGame` pulse at edge k → `Playing` = 0 through edge k+3, `Playing` = 1 after edge k+4.
- **Held goal:** in PLAY, hold `GoalL` high for 10 cycles → left score 01 once, single `ScoreEvent` pulse, `Playing` low for exactly 4 cycles then high.
- **BCD carry and simultaneous goals:**
  - Left at 09, then one `GoalL` edge → `ScoreLTens` = 1, `ScoreLOnes` = 0.
  - `GoalL` and `GoalR` rising in the same cycle → no score change, `Playing` stays 1.
- **Win:**
  - Right at 10, then `GoalR` edge → right score 11, `GameOver` = 1, `Winner` = 1, `Playing` = 0.
  - Further goal edges → no change.
  - `NewGame` edge → scores 00/00, `GameOver` = 0.
- **Reset mid-operation:** left at 05, assert `reset` during SERVE → all outputs 0 within the same cycle; after release, state is IDLE.
